// File: rtl/warn_pwm_multi_ctrl.sv
// Multi-channel PWM for the warning LED/buzzer drivers, with an Avalon-MM register slave.
// Period, prescale and duty writes land in shadows and reach the counters only at a period wrap.
module warn_pwm_multi_ctrl #(
  parameter int CHANNELS     = 2,
  parameter int CNT_W        = 16,
  parameter int ADDR_W       = 3,
  parameter int RESET_PERIOD = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [CHANNELS-1:0] out_port,
  output logic                irq
);

  localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_PERIOD = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_PRE    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(3);

  logic [CHANNELS-1:0] en_q;
  logic                irq_en_q;
  logic [CNT_W-1:0]    period_sh_q, period_act_q;
  logic [CNT_W-1:0]    pre_sh_q, pre_act_q;
  logic [CNT_W-1:0]    duty_sh_q  [CHANNELS];
  logic [CNT_W-1:0]    duty_act_q [CHANNELS];
  logic [CNT_W-1:0]    pcnt_q, pcnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wrap_q, wrap_d;
  logic [CHANNELS-1:0] out_q, out_d;

  logic             wr_en;
  logic             run;
  logic             tick;
  logic             wrap_evt;
  logic             load_act;
  logic             w1c;
  logic [CNT_W-1:0] wdata_cnt;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wdata_cnt    = writedata[CNT_W-1:0];
  assign unused_wdata = ^writedata;
  assign run          = |en_q;
  assign tick         = run & (pcnt_q == pre_act_q);
  assign wrap_evt     = tick & (cnt_q == period_act_q);
  // While idle the active copies track the shadows, so enabling starts a clean period.
  assign load_act     = ~run | wrap_evt;
  assign w1c          = wr_en & (address == ADDR_STATUS) & writedata[0];

  always_comb begin
    pcnt_d = pcnt_q;
    cnt_d  = cnt_q;
    if (!run) begin
      pcnt_d = '0;
      cnt_d  = '0;
    end else if (tick) begin
      pcnt_d = '0;
      cnt_d  = wrap_evt ? '0 : cnt_q + CNT_W'(1);
    end else begin
      pcnt_d = pcnt_q + CNT_W'(1);
    end
  end

  // A wrap in the same cycle as a W1C keeps the flag set.
  assign wrap_d = wrap_evt | (wrap_q & ~w1c);

  always_comb begin
    out_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      out_d[c] = en_q[c] & (cnt_q < duty_act_q[c]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q         <= '0;
      irq_en_q     <= 1'b0;
      period_sh_q  <= CNT_W'(RESET_PERIOD);
      period_act_q <= CNT_W'(RESET_PERIOD);
      pre_sh_q     <= '0;
      pre_act_q    <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        duty_sh_q[c]  <= '0;
        duty_act_q[c] <= '0;
      end
      pcnt_q <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      out_q  <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      out_q  <= out_d;
      if (load_act) begin
        period_act_q <= period_sh_q;
        pre_act_q    <= pre_sh_q;
        for (int c = 0; c < CHANNELS; c++) begin
          duty_act_q[c] <= duty_sh_q[c];
        end
      end
      if (wr_en) begin
        if (address == ADDR_CTRL) begin
          en_q     <= writedata[CHANNELS-1:0];
          irq_en_q <= writedata[31];
        end
        if (address == ADDR_PERIOD) period_sh_q <= wdata_cnt;
        if (address == ADDR_PRE)    pre_sh_q    <= wdata_cnt;
        for (int c = 0; c < CHANNELS; c++) begin
          if (address == ADDR_W'(4 + c)) duty_sh_q[c] <= wdata_cnt;
        end
      end
    end
  end

  always_comb begin
    readdata = '0;
    if (address == ADDR_CTRL) begin
      readdata[CHANNELS-1:0] = en_q;
      readdata[31]           = irq_en_q;
    end else if (address == ADDR_PERIOD) begin
      readdata[CNT_W-1:0] = period_sh_q;
    end else if (address == ADDR_PRE) begin
      readdata[CNT_W-1:0] = pre_sh_q;
    end else if (address == ADDR_STATUS) begin
      readdata[0] = wrap_q;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (address == ADDR_W'(4 + c)) readdata[CNT_W-1:0] = duty_sh_q[c];
      end
    end
  end

  assign out_port = out_q;
  assign irq      = wrap_q & irq_en_q;

endmodule

// File: doc/warn_pwm_multi_ctrl.md
Name: warn_pwm_multi_ctrl

Overview:
- Parametrised multi-channel PWM generator for the warning-indicator outputs; successor to the fixed 2-bit warn PWM control port.
- Avalon-MM slave (zero-wait write, combinational read) exposes a control register, a shared period, a prescaler, a status register and per-channel duty registers.
- Period and duty writes are double-buffered and applied only at the period boundary, so outputs never glitch mid-cycle.
- Sits between the Nios register bus and the warning LED/buzzer drivers.

Parameters:
- CHANNELS, 2, number of PWM outputs (1..16).
- CNT_W, 16, width of period, duty and prescale registers (2..31).
- ADDR_W, 3, slave address width; must satisfy 4+CHANNELS <= 2**ADDR_W.
- RESET_PERIOD, 255, reset value of the period register.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  ADDR_W  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; valid only with chipselect.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address.
- out_port  out  CHANNELS  registered PWM outputs.
- irq  out  1  level interrupt = STATUS.WRAP & CTRL.IRQ_EN.

Behaviour:
- Register map (word addresses):
  - 0 CTRL: bits[CHANNELS-1:0] EN per channel; bit 31 IRQ_EN.
  - 1 PERIOD: shadow period P.
  - 2 PRESCALE: shadow prescale S.
  - 3 STATUS: bit 0 WRAP, sticky; write 1 clears.
  - 4+c DUTY[c]: shadow duty of channel c.
- Writes take effect at the clock edge when chipselect & ~write_n; writedata is truncated to the register width.
- Reads return shadow values zero-extended to 32 bits. Unmapped addresses and unused bits read 0.
- Reset values: CTRL=0, PERIOD shadow/active=RESET_PERIOD, PRESCALE=0, all DUTY=0, STATUS=0, counters=0, out_port=0, irq=0.
- RUN = |CTRL.EN.
- Prescaler: pcnt counts 0..S; tick=1 when pcnt==S_active, and pcnt then returns to 0. S=0 gives a tick every clk.
- Main counter: on tick, cnt increments. When cnt==P_active on a tick (the wrap event), cnt goes to 0. Period = (P+1)*(S+1) clks.
- Wrap event: load P_active, S_active and DUTY_active[c] from their shadows, and set STATUS.WRAP.
- RUN=0: cnt and pcnt are held at 0, and active registers load from shadow every clk. The first cycle after enabling therefore starts at cnt=0 with the current shadow values.
- out_port[c] <= EN[c] & (cnt < DUTY_active[c]). This is registered, 1 clk latency from cnt.
  - DUTY=0 gives constant 0.
  - DUTY>P gives constant 1.
  - Clearing EN[c] drives the output low on the next clk.
- Simultaneous events:
  - Shadow write on the wrap cycle: active loads the old shadow; the new value applies at the next wrap.
  - WRAP set and W1C in the same cycle: set wins.
  - Writing P below the current cnt takes effect only at the next wrap, never mid-period.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); out_port goes to 0 without waiting for a clock.

Test Plan:
- Reset, then read all addresses -> PERIOD=255, all others 0; out_port=0; irq=0.
- P=9, S=0, DUTY0=3, CTRL=1 -> out_port[0] repeats 3 clks high / 7 low (period 10); out_port[1]=0; WRAP set after 10 clks.
- P=4, S=2, DUTY1=5, CTRL=2 -> out_port[1] constant 1; cnt advances every 3 clks; WRAP sets every 15 clks.
- Running P=9, DUTY0=3; write DUTY0=8 at cnt=5 -> remainder of the current period keeps duty 3; the next period is 8 high / 2 low. Also repeat with the write landing exactly on the wrap cycle -> new duty is delayed by one extra period.
- CTRL=0x80000001; wait for WRAP -> irq=1. Write STATUS=1 on a non-wrap cycle -> irq=0. Write STATUS=1 on a wrap cycle -> WRAP remains 1.
- Assert reset_n low mid-period with out_port=1 -> out_port=0 asynchronously; after release, registers are at reset values and outputs stay low until re-enabled.
